// File: rtl/pkt_sync_framer.sv
// pkt_sync_framer: upstream framing stage of the packet parser.
// Accepts a 32-bit valid/ready beat stream with sop/eop, prefixes every
// packet with SYNC_WORD, truncates packets longer than MAX_WORDS payload
// beats, discards beats that arrive outside a packet, and keeps saturating
// statistics counters. The output is a single registered valid/ready stage.
module pkt_sync_framer #(
    parameter logic [31:0] SYNC_WORD = 32'hDEADBEEF,
    parameter int unsigned MAX_WORDS = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             in_ready,
    output logic [31:0]      bus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sync,
    output logic             out_eop,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] trunc_count,
    output logic [CNT_W-1:0] stray_count
);

    // Wide enough to hold MAX_WORDS itself (reached when a full-length
    // packet ends on its own eop).
    localparam int unsigned WC_W = $clog2(MAX_WORDS + 1);
    localparam logic [WC_W-1:0] LAST_IDX = WC_W'(MAX_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        DROP
    } state_t;

    state_t          state;
    logic [WC_W-1:0] word_cnt;
    logic            slot_free;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign slot_free = !out_valid || out_ready;

    // Input handshake: the sop beat is held in IDLE until its sync word
    // has been loaded; stray and dropped beats are always absorbed.
    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    in_ready = in_valid && !in_sop;
                DATA:    in_ready = slot_free;
                DROP:    in_ready = 1'b1;
                default: in_ready = 1'b0;
            endcase
        end
    end

    // Framing FSM, output register and statistics counters.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            word_cnt    <= '0;
            bus         <= '0;
            out_valid   <= 1'b0;
            out_sync    <= 1'b0;
            out_eop     <= 1'b0;
            pkt_count   <= '0;
            trunc_count <= '0;
            stray_count <= '0;
        end else begin
            // A load below overrides this clear in the same cycle.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_sop) begin
                            if (slot_free) begin
                                bus       <= SYNC_WORD;
                                out_valid <= 1'b1;
                                out_sync  <= 1'b1;
                                out_eop   <= 1'b0;
                                pkt_count <= sat_inc(pkt_count);
                                word_cnt  <= '0;
                                state     <= DATA;
                            end
                        end else begin
                            stray_count <= sat_inc(stray_count);
                        end
                    end
                end

                DATA: begin
                    if (in_valid && slot_free) begin
                        bus       <= in_data;
                        out_valid <= 1'b1;
                        out_sync  <= 1'b0;
                        word_cnt  <= word_cnt + WC_W'(1);
                        if (in_eop) begin
                            out_eop <= 1'b1;
                            state   <= IDLE;
                        end else if (word_cnt == LAST_IDX) begin
                            out_eop     <= 1'b1;
                            trunc_count <= sat_inc(trunc_count);
                            state       <= DROP;
                        end else begin
                            out_eop <= 1'b0;
                        end
                    end
                end

                DROP: begin
                    if (in_valid && in_eop) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
